hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; clock port clk, reset port rst.
REQ-002 Parameter NUM_REGS, 32: architectural register count; REG_AW = $clog2(NUM_REGS).
REQ-003 Parameter LAT_W, 4: width of the long-latency countdown; max latency is 2^LAT_W-1.
REQ-004 Parameter PERF_W, 16: width of the stall performance counter.
REQ-005 Ports SHALL be:
 clk  in  1  clock
 rst  in  1  async active-high reset
 Rs1D, Rs2D, RdD  in  REG_AW  decode sources/destination
 RegWriteD, long_op_d  in  1  decode writes RdD / is long-latency op
 Rs1E, Rs2E, RdE  in  REG_AW  execute sources/destination
 memoryRead_e  in  1  load in execute
 long_issue_e  in  1  long-latency op in execute
 long_lat_e  in  LAT_W  cycles until its result reaches writeback, valid 1..max
 long_wb_valid  in  1  long-op result retiring this cycle
 long_wb_rd  in  REG_AW  its destination
 destReg_m, destReg_w  in  REG_AW  memory/writeback destinations
 RegWriteM, RegWriteW  in  1  memory/writeback write enables
 zero_hazard, jump_hazard  in  1  branch taken / jump, resolved in execute
 mem_stall  in  1  memory/cache stall
 ForwardAE, ForwardBE  out  2  forwarding select
 StallF, StallD  out  1  hold fetch/decode registers
 FlushD, FlushE  out  1  flush decode/execute registers
 long_busy  out  1  long-latency unit occupied
 stall_count  out  PERF_W  saturating stalled-cycle count

Function
REQ-006 ForwardAE/BE SHALL be 10 when RegWriteM, destReg_m!=0, destReg_m==Rs1E/Rs2E; else 01 on the same test with W; else 00; M has priority.
REQ-007 Load-use hazard SHALL be memoryRead_e && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
REQ-008 Scoreboard: one pending bit per register; bit 0 SHALL never be set.
REQ-009 Accepted issue = long_issue_e && !mem_stall && !FlushE; on accepted issue with RdE!=0, pending[RdE] SHALL be set at the next edge.
REQ-010 On long_wb_valid, pending[long_wb_rd] SHALL be cleared at the next edge; same-cycle set and clear of one register: set wins.
REQ-011 RAW stall SHALL assert when pending[Rs1D] or pending[Rs2D] (nonzero sources).
REQ-012 WAW stall SHALL assert when RegWriteD && RdD!=0 && pending[RdD].
REQ-013 On accepted issue, busy counter SHALL load long_lat_e; otherwise it decrements by one when nonzero, independent of mem_stall; long_busy = counter!=0.
REQ-014 Structural stall SHALL assert when long_op_d && (long_busy || long_issue_e).
REQ-015 Priority: mem_stall SHALL give StallF=StallD=1, FlushD=FlushE=0; else control hazard (zero_hazard||jump_hazard) SHALL give FlushD=FlushE=1, Stall*=0, overriding data stalls; else any of REQ-007/011/012/014 SHALL give StallF=StallD=FlushE=1, FlushD=0; else all 0.
REQ-016 stall_count SHALL increment each cycle StallD=1 and saturate at all-ones.
REQ-017 Data stalls SHALL release the cycle after the blocking pending bit clears; no extra bubble.

Reset
REQ-018 rst SHALL asynchronously clear all pending bits, busy counter and stall_count; with all inputs zero, every output SHALL read 0.
REQ-019 Reset mid-operation SHALL abandon an in-flight long op; a long_wb_valid arriving after reset SHALL clear only (already-clear) bits.

Structure
REQ-020 Package hazard_pkg SHALL hold fwd_sel_t (FWD_RF=00, FWD_WB=01, FWD_MEM=10) and default parameter constants.
REQ-021 Sub-module hazard_fwd_sel (combinational, REQ-006) SHALL be instantiated twice, for A and B.
REQ-022 Outputs other than stall_count and long_busy SHALL be combinational from inputs and state.

Verification
REQ-023 RegWriteM=1, destReg_m=5, RegWriteW=1, destReg_w=5, Rs1E=5 -> ForwardAE=10; destReg_m=0 -> 01.
REQ-024 Issue long_lat_e=3, RdE=7; next cycle Rs1D=7 -> StallD=1, FlushE=1 until long_wb_valid rd=7, released the following cycle; long_busy high exactly 3 cycles.
REQ-025 Pending[9] set, RegWriteD=1, RdD=9 -> WAW stall; RdD=0 -> no stall.
REQ-026 Load-use (RdE=4, Rs2D=4) with jump_hazard=1 -> FlushD=FlushE=1, StallD=0; add mem_stall=1 -> StallF=StallD=1, flushes 0.
REQ-027 long_op_d=1 while long_busy=1 -> structural stall; rst asserted mid-op -> long_busy=0, pending clear same cycle.
REQ-028 PERF_W=4, hold stall 20 cycles -> stall_count=15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and default sizes for the hazard scoreboard.
// Forwarding select encoding used by the execute-stage operand muxes.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    localparam int NUM_REGS_DEF = 32;
    localparam int LAT_W_DEF    = 4;
    localparam int PERF_W_DEF   = 16;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one execute-stage source operand.
// The memory stage is younger than writeback, so it wins.
module hazard_fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_e_i,
    input  logic [REG_AW-1:0] rd_m_i,
    input  logic [REG_AW-1:0] rd_w_i,
    input  logic              we_m_i,
    input  logic              we_w_i,
    output fwd_sel_t          sel_o
);

    // Pick the youngest in-flight producer of rs_e_i; x0 never forwards.
    always_comb begin
        sel_o = FWD_RF;
        if (we_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i)) begin
            sel_o = FWD_MEM;
        end else if (we_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit with a long-latency register scoreboard.
// Produces forwarding selects, stall/flush controls and a stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int LAT_W    = LAT_W_DEF,
    parameter  int PERF_W   = PERF_W_DEF,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              long_op_d,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              memoryRead_e,
    input  logic              long_issue_e,
    input  logic [LAT_W-1:0]  long_lat_e,
    input  logic              long_wb_valid,
    input  logic [REG_AW-1:0] long_wb_rd,
    input  logic [REG_AW-1:0] destReg_m,
    input  logic [REG_AW-1:0] destReg_w,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              zero_hazard,
    input  logic              jump_hazard,
    input  logic              mem_stall,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              long_busy,
    output logic [PERF_W-1:0] stall_count
);

    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [LAT_W-1:0]    busy_q, busy_d;
    logic [PERF_W-1:0]   cnt_q, cnt_d;

    fwd_sel_t fwd_a, fwd_b;
    logic     issue_ok;
    logic     load_use, raw_stall, waw_stall, struct_stall;
    logic     data_stall, ctrl_hazard;

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs_e_i (Rs1E),
        .rd_m_i (destReg_m),
        .rd_w_i (destReg_w),
        .we_m_i (RegWriteM),
        .we_w_i (RegWriteW),
        .sel_o  (fwd_a)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs_e_i (Rs2E),
        .rd_m_i (destReg_m),
        .rd_w_i (destReg_w),
        .we_m_i (RegWriteM),
        .we_w_i (RegWriteW),
        .sel_o  (fwd_b)
    );

    assign ForwardAE = fwd_a;
    assign ForwardBE = fwd_b;

    // Decode-side hazard detection against execute and the scoreboard.
    always_comb begin
        load_use     = memoryRead_e && (RdE != '0) &&
                       ((RdE == Rs1D) || (RdE == Rs2D));
        raw_stall    = ((Rs1D != '0) && pend_q[Rs1D]) ||
                       ((Rs2D != '0) && pend_q[Rs2D]);
        waw_stall    = RegWriteD && (RdD != '0) && pend_q[RdD];
        struct_stall = long_op_d && (long_busy || long_issue_e);
        data_stall   = load_use || raw_stall || waw_stall || struct_stall;
        ctrl_hazard  = zero_hazard || jump_hazard;
    end

    // Memory stall freezes everything, then redirects, then data bubbles.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
        end else if (ctrl_hazard) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (data_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign issue_ok  = long_issue_e && !mem_stall && !FlushE;
    assign long_busy = (busy_q != '0);

    // Scoreboard update: retire clears first so a same-cycle issue wins.
    always_comb begin
        pend_d = pend_q;
        if (long_wb_valid) begin
            pend_d[long_wb_rd] = 1'b0;
        end
        if (issue_ok && (RdE != '0)) begin
            pend_d[RdE] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Occupancy countdown for the long-latency unit.
    always_comb begin
        busy_d = busy_q;
        if (issue_ok) begin
            busy_d = long_lat_e;
        end else if (busy_q != '0) begin
            busy_d = busy_q - LAT_W'(1);
        end
    end

    // Saturating count of cycles where decode is held.
    always_comb begin
        cnt_d = cnt_q;
        if (StallD && (cnt_q != '1)) begin
            cnt_d = cnt_q + PERF_W'(1);
        end
    end

    assign stall_count = cnt_q;

    // State registers; reset abandons any in-flight long op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_hazard_scoreboard;

    localparam int REG_AW = 5;
    localparam int LAT_W  = 4;
    localparam int PERF_W = 4;

    logic              clk;
    logic              rst;
    logic [REG_AW-1:0] Rs1D, Rs2D, RdD;
    logic              RegWriteD, long_op_d;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
    logic              memoryRead_e, long_issue_e;
    logic [LAT_W-1:0]  long_lat_e;
    logic              long_wb_valid;
    logic [REG_AW-1:0] long_wb_rd;
    logic [REG_AW-1:0] destReg_m, destReg_w;
    logic              RegWriteM, RegWriteW;
    logic              zero_hazard, jump_hazard, mem_stall;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              StallF, StallD, FlushD, FlushE, long_busy;
    logic [PERF_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard #(
        .NUM_REGS (32),
        .LAT_W    (LAT_W),
        .PERF_W   (PERF_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .Rs1D          (Rs1D),
        .Rs2D          (Rs2D),
        .RdD           (RdD),
        .RegWriteD     (RegWriteD),
        .long_op_d     (long_op_d),
        .Rs1E          (Rs1E),
        .Rs2E          (Rs2E),
        .RdE           (RdE),
        .memoryRead_e  (memoryRead_e),
        .long_issue_e  (long_issue_e),
        .long_lat_e    (long_lat_e),
        .long_wb_valid (long_wb_valid),
        .long_wb_rd    (long_wb_rd),
        .destReg_m     (destReg_m),
        .destReg_w     (destReg_w),
        .RegWriteM     (RegWriteM),
        .RegWriteW     (RegWriteW),
        .zero_hazard   (zero_hazard),
        .jump_hazard   (jump_hazard),
        .mem_stall     (mem_stall),
        .ForwardAE     (ForwardAE),
        .ForwardBE     (ForwardBE),
        .StallF        (StallF),
        .StallD        (StallD),
        .FlushD        (FlushD),
        .FlushE        (FlushE),
        .long_busy     (long_busy),
        .stall_count   (stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        Rs1D = '0; Rs2D = '0; RdD = '0;
        RegWriteD = 1'b0; long_op_d = 1'b0;
        Rs1E = '0; Rs2E = '0; RdE = '0;
        memoryRead_e = 1'b0; long_issue_e = 1'b0; long_lat_e = '0;
        long_wb_valid = 1'b0; long_wb_rd = '0;
        destReg_m = '0; destReg_w = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        zero_hazard = 1'b0; jump_hazard = 1'b0; mem_stall = 1'b0;
    endtask

    initial begin
        clr();
        rst = 1'b1;

        // reset state
        @(negedge clk); #1;
        chk("rst_fwda", 32'(ForwardAE), 0);
        chk("rst_fwdb", 32'(ForwardBE), 0);
        chk("rst_stallf", 32'(StallF), 0);
        chk("rst_stalld", 32'(StallD), 0);
        chk("rst_flushd", 32'(FlushD), 0);
        chk("rst_flushe", 32'(FlushE), 0);
        chk("rst_busy", 32'(long_busy), 0);
        chk("rst_cnt", 32'(stall_count), 0);
        rst = 1'b0;

        // forwarding
        @(negedge clk);
        RegWriteM = 1'b1; destReg_m = 5'd5;
        RegWriteW = 1'b1; destReg_w = 5'd5; Rs1E = 5'd5;
        #1;
        chk("fwd_mem_pri", 32'(ForwardAE), 2);
        chk("fwd_b_none", 32'(ForwardBE), 0);
        destReg_m = 5'd0; #1;
        chk("fwd_wb_a", 32'(ForwardAE), 1);
        Rs2E = 5'd5; #1;
        chk("fwd_wb_b", 32'(ForwardBE), 1);
        @(negedge clk);
        destReg_w = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; #1;
        chk("fwd_x0", 32'(ForwardAE), 0);
        Rs1E = 5'd6; destReg_m = 5'd6; RegWriteM = 1'b0; #1;
        chk("fwd_no_we", 32'(ForwardAE), 0);

        // long op to x7, RAW stall until retire
        @(negedge clk); clr();
        long_issue_e = 1'b1; long_lat_e = 4'd3; RdE = 5'd7; #1;
        chk("iss_busy0", 32'(long_busy), 0);
        chk("iss_stall0", 32'(StallD), 0);
        @(negedge clk); clr();
        Rs1D = 5'd7; #1;
        chk("raw_stalld", 32'(StallD), 1);
        chk("raw_stallf", 32'(StallF), 1);
        chk("raw_flushe", 32'(FlushE), 1);
        chk("raw_flushd", 32'(FlushD), 0);
        chk("busy_c1", 32'(long_busy), 1);
        @(negedge clk); #1;
        chk("raw_c2", 32'(StallD), 1);
        chk("busy_c2", 32'(long_busy), 1);
        @(negedge clk); #1;
        chk("raw_c3", 32'(StallD), 1);
        chk("busy_c3", 32'(long_busy), 1);
        @(negedge clk); #1;
        chk("busy_c4", 32'(long_busy), 0);
        chk("raw_c4", 32'(StallD), 1);
        long_wb_valid = 1'b1; long_wb_rd = 5'd7; #1;
        chk("raw_wb_cycle", 32'(StallD), 1);
        @(negedge clk);
        long_wb_valid = 1'b0; #1;
        chk("raw_release", 32'(StallD), 0);
        chk("raw_rel_flushe", 32'(FlushE), 0);
        chk("cnt_after_raw", 32'(stall_count), 4);

        // WAW, structural, then reset mid-op
        @(negedge clk); clr();
        long_issue_e = 1'b1; long_lat_e = 4'd2; RdE = 5'd9;
        @(negedge clk); clr();
        RegWriteD = 1'b1; RdD = 5'd9; #1;
        chk("waw_stall", 32'(StallD), 1);
        RdD = 5'd0; #1;
        chk("waw_x0", 32'(StallD), 0);
        long_op_d = 1'b1; #1;
        chk("struct_stall", 32'(StallD), 1);
        @(negedge clk); clr();
        Rs1D = 5'd9; #1;
        chk("busy_mid", 32'(long_busy), 1);
        chk("raw9_stall", 32'(StallD), 1);
        rst = 1'b1; #1;
        chk("rst_mid_busy", 32'(long_busy), 0);
        chk("rst_mid_pend", 32'(StallD), 0);
        chk("rst_mid_cnt", 32'(stall_count), 0);
        @(negedge clk);
        rst = 1'b0; clr();
        long_wb_valid = 1'b1; long_wb_rd = 5'd9;
        @(negedge clk); clr();
        Rs1D = 5'd9; RegWriteD = 1'b1; RdD = 5'd9; #1;
        chk("post_rst_clear", 32'(StallD), 0);

        // same-cycle set and clear of x12: set wins
        @(negedge clk); clr();
        long_issue_e = 1'b1; long_lat_e = 4'd1; RdE = 5'd12;
        long_wb_valid = 1'b1; long_wb_rd = 5'd12;
        @(negedge clk); clr();
        Rs1D = 5'd12; #1;
        chk("set_wins", 32'(StallD), 1);
        long_wb_valid = 1'b1; long_wb_rd = 5'd12;
        @(negedge clk); clr();
        Rs2D = 5'd12; #1;
        chk("x12_release", 32'(StallD), 0);

        // issue rejected under mem_stall and under flush
        @(negedge clk); clr();
        long_issue_e = 1'b1; long_lat_e = 4'd5; RdE = 5'd13;
        mem_stall = 1'b1; #1;
        chk("ms_stallf", 32'(StallF), 1);
        chk("ms_flushe", 32'(FlushE), 0);
        @(negedge clk); clr();
        Rs2D = 5'd13; #1;
        chk("ms_no_pend", 32'(StallD), 0);
        chk("ms_no_busy", 32'(long_busy), 0);
        @(negedge clk); clr();
        long_issue_e = 1'b1; long_lat_e = 4'd5; RdE = 5'd14;
        zero_hazard = 1'b1; #1;
        chk("br_flushd", 32'(FlushD), 1);
        chk("br_flushe", 32'(FlushE), 1);
        @(negedge clk); clr();
        Rs1D = 5'd14; #1;
        chk("br_no_pend", 32'(StallD), 0);
        chk("br_no_busy", 32'(long_busy), 0);

        // load-use vs jump vs mem_stall priority
        @(negedge clk); clr();
        memoryRead_e = 1'b1; RdE = 5'd4; Rs2D = 5'd4; #1;
        chk("lu_stalld", 32'(StallD), 1);
        chk("lu_flushe", 32'(FlushE), 1);
        jump_hazard = 1'b1; #1;
        chk("jmp_flushd", 32'(FlushD), 1);
        chk("jmp_flushe", 32'(FlushE), 1);
        chk("jmp_stalld", 32'(StallD), 0);
        mem_stall = 1'b1; #1;
        chk("ms_pri_stalld", 32'(StallD), 1);
        chk("ms_pri_flushd", 32'(FlushD), 0);
        chk("ms_pri_flushe", 32'(FlushE), 0);
        @(negedge clk); clr();
        memoryRead_e = 1'b1; RdE = 5'd0; #1;
        chk("lu_x0", 32'(StallD), 0);

        // stall counter saturation
        @(negedge clk); clr();
        rst = 1'b1; #1;
        chk("cnt_rst", 32'(stall_count), 0);
        rst = 1'b0;
        mem_stall = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("cnt_5", 32'(stall_count), 5);
        repeat (15) @(negedge clk);
        #1;
        chk("cnt_sat", 32'(stall_count), 15);
        clr();
        @(negedge clk); #1;
        chk("cnt_hold", 32'(stall_count), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
